// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver (8N1-style framing, configurable data width)
// feeding a first-word fall-through receive FIFO with sticky error flags.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN; without it
// frames go DATA->STOP directly and parity_err is tied to 0.
module uart_rx_fifo #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              UART_Rx,
    input  logic                              rd_en,
    input  logic                              clr_err,
    output logic [DATA_BITS-1:0]              rd_data,
    output logic                              empty,
    output logic                              full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
    output logic                              frame_err,
    output logic                              overrun_err,
    output logic                              parity_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DBIT_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [CW-1:0]    DEPTH_C  = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // synchronizer and edge detect
    logic sync1_q, sync2_q, prev_q;

    // receiver state
    state_t               state_q;
    logic [CNT_W-1:0]     clk_cnt_q;
    logic [BIT_W-1:0]     bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q;
`endif

    // FIFO storage
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q, count_d;

    logic frame_err_q, overrun_err_q, parity_err_q;

    logic fall, stop_tick, word_ok, pop, accept, frame_set, overrun_set, parity_set;

    // Falling edge seen only on synchronized samples; prev_q resets high so an
    // idle-high line after reset never looks like a start bit.
    assign fall      = prev_q & ~sync2_q;
    assign stop_tick = (state_q == STOP) && (clk_cnt_q == BIT_LAST);
`ifdef UART_RX_PARITY_EN
    assign word_ok    = stop_tick & sync2_q & ~par_bad_q;
    assign parity_set = stop_tick & par_bad_q;
`else
    assign word_ok    = stop_tick & sync2_q;
    assign parity_set = 1'b0;
`endif
    assign frame_set   = stop_tick & ~sync2_q;
    assign pop         = rd_en & ~empty;
    // A full FIFO still takes the word when the head leaves in the same cycle.
    assign accept      = word_ok & (~full | pop);
    assign overrun_set = word_ok & ~accept;

    // 2-flop synchronizer plus one history flop for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= UART_Rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // receive FSM: mid-bit sampling via a per-bit cycle counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    clk_cnt_q <= '0;
                    if (fall) begin
                        state_q   <= START;
                        bit_cnt_q <= '0;
                    end
                end
                START: begin
                    if (clk_cnt_q == HALF_M1) begin
                        clk_cnt_q <= '0;
                        state_q   <= sync2_q ? IDLE : DATA;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (clk_cnt_q == BIT_LAST) begin
                        clk_cnt_q <= '0;
                        shift_q   <= {sync2_q, shift_q[DATA_BITS-1:1]};
                        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                        if (bit_cnt_q == DBIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end
                end
                PARITY: begin
                    if (clk_cnt_q == BIT_LAST) begin
                        clk_cnt_q <= '0;
                        state_q   <= STOP;
`ifdef UART_RX_PARITY_EN
                        // even parity: data ones plus parity bit must be even
                        par_bad_q <= (^shift_q) ^ sync2_q;
`endif
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (clk_cnt_q == BIT_LAST) begin
                        clk_cnt_q <= '0;
                        state_q   <= IDLE;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    clk_cnt_q <= '0;
                end
            endcase
        end
    end

    // next occupancy from push/pop pair
    always_comb begin
        count_d = count_q;
        case ({accept, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage and pointers; storage resets so rd_data reads 0 out of reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) begin
                mem_q[wr_ptr_q] <= shift_q;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // sticky error flags; a new error in the clear cycle wins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
            parity_err_q  <= 1'b0;
        end else begin
            if (frame_set)        frame_err_q   <= 1'b1;
            else if (clr_err)     frame_err_q   <= 1'b0;
            if (overrun_set)      overrun_err_q <= 1'b1;
            else if (clr_err)     overrun_err_q <= 1'b0;
            if (parity_set)       parity_err_q  <= 1'b1;
            else if (clr_err)     parity_err_q  <= 1'b0;
        end
    end

    assign rd_data     = mem_q[rd_ptr_q];
    assign count       = count_q;
    assign empty       = (count_q == '0);
    assign full        = (count_q == DEPTH_C);
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_err_q;
    assign parity_err  = parity_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed + randomized frames against a queue-based model
// of the receiver/FIFO (DATA_BITS=8, CLKS_PER_BIT=4, FIFO_DEPTH=4).
module tb_uart_rx_fifo;

    localparam int DB  = 8;
    localparam int CPB = 4;
    localparam int DEP = 4;

    logic          clk, rst, UART_Rx, rd_en, clr_err;
    logic [DB-1:0] rd_data;
    logic          empty, full, frame_err, overrun_err, parity_err;
    logic [2:0]    count;

    int n_cmp = 0;
    int n_err = 0;

    // reference model
    int q[$];
    bit m_fe, m_oe, m_pe;

    uart_rx_fifo #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEP)) dut (
        .clk(clk), .rst(rst), .UART_Rx(UART_Rx), .rd_en(rd_en), .clr_err(clr_err),
        .rd_data(rd_data), .empty(empty), .full(full), .count(count),
        .frame_err(frame_err), .overrun_err(overrun_err), .parity_err(parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(q.size()));
        chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
        chk({tag, ".full"},  32'(full),  32'(q.size() == DEP));
        chk({tag, ".ferr"},  32'(frame_err),   32'(m_fe));
        chk({tag, ".oerr"},  32'(overrun_err), 32'(m_oe));
        chk({tag, ".perr"},  32'(parity_err),  32'(m_pe));
        if (q.size() > 0) chk({tag, ".head"}, 32'(rd_data), 32'(q[0]));
    endtask

    // one frame, bit period CPB; optional rd_en pulse aligned to the stop sample
    task automatic send_frame(input logic [7:0] d, input bit stop, input bit par, input bit rd_at_stop);
        bit popped, ok, pbad;
        UART_Rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < DB; i++) begin
            UART_Rx = d[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        UART_Rx = par;
        repeat (CPB) @(negedge clk);
        pbad = ((^d) ^ par) != 1'b0;
`else
        pbad = 1'b0;
        if (par) pbad = 1'b0;
`endif
        UART_Rx = stop;
        repeat (CPB - 1) @(negedge clk);
        if (rd_at_stop) rd_en = 1'b1;
        @(negedge clk);
        rd_en   = 1'b0;
        UART_Rx = 1'b1;
        repeat (6) @(negedge clk);
        // model: frame rules, then FIFO acceptance with same-cycle pop
        popped = rd_at_stop && q.size() > 0;
        if (popped) void'(q.pop_front());
        ok = stop && !pbad;
        if (!stop) m_fe = 1'b1;
        if (pbad)  m_pe = 1'b1;
        if (ok) begin
            if (q.size() < DEP) q.push_back(int'(d));
            else m_oe = 1'b1;
        end
    endtask

    task automatic do_read();
        if (q.size() > 0) chk("read.head", 32'(rd_data), 32'(q[0]));
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
        if (q.size() > 0) void'(q.pop_front());
    endtask

    task automatic do_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        @(negedge clk);
        m_fe = 0; m_oe = 0; m_pe = 0;
    endtask

    function automatic bit even_par(input logic [7:0] d);
        return ^d;
    endfunction

    initial begin
        logic [7:0] d;
        rst = 1'b0; UART_Rx = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
        m_fe = 0; m_oe = 0; m_pe = 0;
        repeat (3) @(negedge clk);
        check_state("reset");
        chk("reset.rd_data", 32'(rd_data), 32'h0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // single good frame
        send_frame(8'hA5, 1'b1, even_par(8'hA5), 1'b0);
        check_state("a5");
        do_read();
        check_state("a5.read");

        // overflow: five frames into a four-entry FIFO
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, even_par(8'(i)), 1'b0);
        check_state("ovf");
        for (int i = 0; i < 4; i++) do_read();
        check_state("ovf.drain");
        do_clr();
        check_state("ovf.clr");

        // framing error, then clear
        send_frame(8'h3C, 1'b0, even_par(8'h3C), 1'b0);
        check_state("ferr");
        do_clr();
        check_state("ferr.clr");

        // one-cycle glitch on idle line, then a good frame must still decode
        UART_Rx = 1'b0;
        @(negedge clk);
        UART_Rx = 1'b1;
        repeat (12) @(negedge clk);
        check_state("glitch");
        send_frame(8'h5A, 1'b1, even_par(8'h5A), 1'b0);
        check_state("glitch.after");
        do_read();

        // full FIFO with pop on the stop-sample cycle
        for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1, even_par(8'h10 + 8'(i)), 1'b0);
        check_state("full.pre");
        send_frame(8'h14, 1'b1, even_par(8'h14), 1'b1);
        check_state("full.pushpop");
        for (int i = 0; i < 4; i++) do_read();
        check_state("full.drain");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, 1'b0);
        check_state("par.bad");
        do_clr();
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        check_state("par.good");
        do_read();
`endif

        // randomized traffic
        for (int it = 0; it < 40; it++) begin
            bit stop, par, rds;
            d    = 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            par  = even_par(d) ^ ($urandom_range(0, 7) == 0);
            rds  = ($urandom_range(0, 3) == 0);
            send_frame(d, stop, par, rds);
            check_state("rnd.frame");
            for (int r = $urandom_range(0, 1); r > 0; r--) do_read();
            if ($urandom_range(0, 5) == 0) do_clr();
            check_state("rnd.post");
        end

        // reset in the middle of a frame abandons it
        UART_Rx = 1'b0;
        repeat (CPB) @(negedge clk);
        UART_Rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        UART_Rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rst = 1'b0;
        UART_Rx = 1'b1;
        q.delete(); m_fe = 0; m_oe = 0; m_pe = 0;
        @(negedge clk);
        check_state("midrst");
        chk("midrst.rd_data", 32'(rd_data), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (60) @(negedge clk);
        check_state("midrst.idle");
        send_frame(8'hC3, 1'b1, even_par(8'hC3), 1'b0);
        check_state("midrst.frame");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
